// File: rtl/nx_fifo_rd_stream.sv
// Show-ahead FIFO read adapter: prefetches up to two upstream words into a
// registered output buffer so the consumer sees a valid/ready stream.
module nx_fifo_rd_stream #(
    parameter int N_DATA_BITS = 32,
    parameter int N_CNT_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [N_DATA_BITS-1:0] fifo_rd_data,
    output logic                   fifo_rd,
    output logic                   out_valid,
    output logic [N_DATA_BITS-1:0] out_data,
    input  logic                   out_ready,
    input  logic                   flush,
    input  logic                   cnt_clr,
    output logic [N_CNT_BITS-1:0]  word_cnt,
    output logic [1:0]             occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [N_CNT_BITS-1:0] CNT_MAX = '1;

    state_t                 r_state, w_state_next;
    logic                   r_valid, w_valid_next;
    logic [1:0]             r_occ, w_occ_next;
    logic [N_DATA_BITS-1:0] r_slot0, r_slot1, w_slot0_next, w_slot1_next;
    logic [N_CNT_BITS-1:0]  r_cnt, w_cnt_next;
    logic                   w_push, w_pop;

    // fifo_rd depends only on registered state and upstream/flush inputs,
    // never on out_ready; rst_n gating keeps it low during async reset.
    assign fifo_rd = rst_n & ~fifo_empty & ~flush & (r_state != ST_TWO);
    assign w_push  = fifo_rd;
    assign w_pop   = r_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_slot0_next = r_slot0;
        w_slot1_next = r_slot1;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_ONE;
                    w_slot0_next = fifo_rd_data;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_slot0_next = fifo_rd_data;
                end else if (w_push) begin
                    w_state_next = ST_TWO;
                    w_slot1_next = fifo_rd_data;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_next = ST_ONE;
                    w_slot0_next = r_slot1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase

        // A handshake in the flush cycle still completes; everything left is dropped.
        if (flush) begin
            w_state_next = ST_EMPTY;
        end

        w_valid_next = 1'b0;
        w_occ_next   = 2'd0;
        case (w_state_next)
            ST_ONE: begin
                w_valid_next = 1'b1;
                w_occ_next   = 2'd1;
            end
            ST_TWO: begin
                w_valid_next = 1'b1;
                w_occ_next   = 2'd2;
            end
            default: begin
                w_valid_next = 1'b0;
                w_occ_next   = 2'd0;
            end
        endcase

        w_cnt_next = r_cnt;
        if (cnt_clr) begin
            w_cnt_next = '0;
        end else if (w_pop && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_occ   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_occ   <= w_occ_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Data slots carry no reset; their contents are qualified by r_valid.
    always_ff @(posedge clk) begin
        r_slot0 <= w_slot0_next;
        r_slot1 <= w_slot1_next;
    end

    assign out_valid = r_valid;
    assign out_data  = r_slot0;
    assign word_cnt  = r_cnt;
    assign occupancy = r_occ;

endmodule

// File: doc/nx_fifo_rd_stream.md
NX_FIFO_RD_STREAM -- requirements
Module: nx_fifo_rd_stream

Interface
REQ-001 SHALL have parameter N_DATA_BITS, default 32, width of the FIFO word and the output data.
REQ-002 SHALL have parameter N_CNT_BITS, default 16, width of the delivered-word counter.
REQ-003 SHALL have clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have fifo_empty, input, 1, upstream FIFO has no readable word.
REQ-006 SHALL have fifo_rd_data, input, N_DATA_BITS, upstream head word; valid in any cycle where fifo_empty=0 (show-ahead).
REQ-007 SHALL have fifo_rd, output, 1, pops the upstream FIFO head this cycle.
REQ-008 SHALL have out_valid, output, 1, out_data holds a valid word.
REQ-009 SHALL have out_data, output, N_DATA_BITS, head word of the internal buffer.
REQ-010 SHALL have out_ready, input, 1, consumer accepts out_data this cycle.
REQ-011 SHALL have flush, input, 1, synchronous discard of buffered words.
REQ-012 SHALL have cnt_clr, input, 1, synchronous clear of word_cnt.
REQ-013 SHALL have word_cnt, output, N_CNT_BITS, count of completed output handshakes.
REQ-014 SHALL have occupancy, output, 2, number of words buffered (0..2).

Function
REQ-015 SHALL hold a 2-entry buffer (slot0 = head, slot1) with state EMPTY (occ 0), ONE (occ 1) or TWO (occ 2).
REQ-016 SHALL drive out_valid = (occ != 0) and out_data = slot0; both registered, with no combinational path from out_ready.
REQ-017 SHALL define pop = out_valid & out_ready, the output handshake.
REQ-018 SHALL drive fifo_rd = ~fifo_empty & ~flush & (occ < 2), with no dependence on out_ready.
REQ-019 SHALL define push = fifo_rd, capturing fifo_rd_data on the same edge.
REQ-020 SHALL apply these transitions: EMPTY with push goes to ONE. ONE with push only goes to TWO. ONE with pop only goes to EMPTY. ONE with push and pop stays in ONE. TWO with pop goes to ONE. Every other combination holds state.
REQ-021 SHALL write a pushed word into slot0 when occ=0, or when occ=1 with pop; otherwise it SHALL write the word into slot1.
REQ-022 SHALL shift slot1 into slot0 on a pop at occ=2.
REQ-023 SHALL have a latency of 1 cycle: a word popped at edge N is presented with out_valid=1 after edge N.
REQ-024 SHALL sustain 1 word per cycle when fifo_empty=0 and out_ready=1 are held continuously.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush, force occ to 0 at the next edge and keep fifo_rd=0 during the flush cycle.
REQ-027 SHALL, when flush coincides with a handshake, count the handshake in word_cnt and discard all remaining words.
REQ-028 SHALL increment word_cnt by 1 on each pop and saturate at 2^N_CNT_BITS-1 with no wrap.
REQ-029 SHALL, when cnt_clr is asserted, set word_cnt to 0 at the next edge; cnt_clr SHALL win over a simultaneous pop.
REQ-030 SHALL drive occupancy equal to occ from a register.
REQ-031 SHALL treat a word as owned from its pop; no upstream word is ever lost except through flush.

Reset
REQ-032 SHALL, while rst_n=0, hold occ=0, out_valid=0, word_cnt=0 and occupancy=0; out_data and the slots are don't-care.
REQ-033 SHALL, on reset assertion mid-transfer, discard buffered words immediately, with fifo_rd=0 while rst_n=0.
REQ-034 SHALL allow the first fifo_rd at the first clk edge after rst_n deasserts.

Verification
REQ-035 Streaming: fifo_empty=0 with words 1,2,3,... and out_ready=1 held -> out_valid=1 from cycle 1, out_data = 1,2,3 on consecutive cycles, occupancy=1, word_cnt=N after N handshakes.
REQ-036 Backpressure: out_ready=0 with the FIFO non-empty -> exactly 2 fifo_rd pulses, occupancy=2, fifo_rd=0 afterwards, out_data=word1 stable; out_ready=1 then yields words 1,2,3 in order with no loss or duplication.
REQ-037 Flush: occupancy=2, then flush=1 with out_ready=1 for one cycle -> word_cnt+1, occupancy=0 and out_valid=0 the next cycle, fifo_rd=0 during the flush cycle.
REQ-038 Counter: word_cnt preset near saturation (N_CNT_BITS=4 build) and 20 handshakes -> word_cnt=15 held; cnt_clr together with a pop -> word_cnt=0.
REQ-039 Reset mid-operation: occupancy=2, then rst_n pulsed low -> out_valid=0, word_cnt=0 and fifo_rd=0 immediately; the first pop occurs on the first edge after release.
REQ-040 Random: random fifo_empty and out_ready toggling over 10k cycles -> output sequence equals the popped-input sequence; out_data never changes while out_valid=1 and out_ready=0.
